// File: rtl/mem_pkg.sv
// Shared definitions for the block memory and its cache-side users.
package mem_pkg;

  localparam int ADDR_W          = 10;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK;
  localparam int NUM_WORDS       = 256;
  localparam int BLK_IDX_W       = 6;
  localparam int NUM_BLOCKS      = NUM_WORDS / WORDS_PER_BLOCK;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_e;

  // Power-up content of one block: word i holds the value i.
  function automatic logic [BLOCK_W-1:0] init_block(input int unsigned blk);
    logic [BLOCK_W-1:0] v;
    v = '0;
    for (int unsigned w = 0; w < WORDS_PER_BLOCK; w++) begin
      v[w*WORD_W +: WORD_W] = WORD_W'(blk * WORDS_PER_BLOCK + w);
    end
    return v;
  endfunction

endpackage

// File: rtl/mem_array.sv
// 256x32 storage seen as 64 blocks of 4 words, one block-wide port.
module mem_array
  import mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [BLK_IDX_W-1:0] blk_idx,
  input  logic [BLOCK_W-1:0]   wr_data,
  output logic [BLOCK_W-1:0]   rd_data
);

  logic [BLOCK_W-1:0] blk_view [NUM_BLOCKS];

  // Each block is its own register so it can carry a distinct power-up value;
  // the content is never cleared by reset.
  for (genvar b = 0; b < NUM_BLOCKS; b++) begin : g_blk
    logic [BLOCK_W-1:0] blk_q = init_block(b);

    // Block write on the access edge when this block is addressed.
    always_ff @(posedge clk) begin
      if (wr_en && (blk_idx == BLK_IDX_W'(b))) begin
        blk_q <= wr_data;
      end
    end

    assign blk_view[b] = blk_q;
  end

  assign rd_data = blk_view[blk_idx];

endmodule

// File: rtl/block_memory.sv
// Multi-cycle block memory behind the write-back data cache.
module block_memory #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = mem_pkg::ADDR_W,
  parameter int BLOCK_W = mem_pkg::BLOCK_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [BLOCK_W-1:0] req_wdata,
  output logic               resp_valid,
  output logic [BLOCK_W-1:0] resp_rdata
);

  import mem_pkg::*;

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  mem_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [BLK_IDX_W-1:0] blk_q;
  logic                 write_q;
  logic [BLOCK_W-1:0]   wdata_q;
  logic                 accept;
  logic                 access;
  logic                 arr_wr_en;
  logic [BLOCK_W-1:0]   arr_rd_data;
  logic                 unused_offset;

  // Byte offset within a block has no meaning for whole-block transfers.
  assign unused_offset = ^req_addr[ADDR_W-BLK_IDX_W-1:0];

  // Next state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    access     = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latches, latency counter and read-data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      blk_q      <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      resp_rdata <= '0;
    end else begin
      if (accept) begin
        cnt_q   <= CNT_W'(LATENCY - 1);
        blk_q   <= req_addr[ADDR_W-1 -: BLK_IDX_W];
        write_q <= req_write;
        wdata_q <= req_wdata;
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (access && !write_q) begin
        resp_rdata <= arr_rd_data;
      end
    end
  end

  // A reset during WAIT leaves state_q out of WAIT, so the write never fires.
  assign arr_wr_en = access & write_q;

  mem_array u_mem_array (
    .clk     (clk),
    .wr_en   (arr_wr_en),
    .blk_idx (blk_q),
    .wr_data (wdata_q),
    .rd_data (arr_rd_data)
  );

endmodule

// File: tb/tb_block_memory.sv
// Directed scoreboard bench for block_memory (LATENCY=4 and LATENCY=1 builds).
module tb_block_memory;

  localparam int L0 = 4;
  localparam int L1 = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         v0, rdy0, w0, rv0;
  logic [9:0]   a0;
  logic [127:0] wd0, rd0;
  logic         v1, rdy1, w1, rv1;
  logic [9:0]   a1;
  logic [127:0] wd1, rd1;

  always #5 clk = ~clk;

  block_memory #(.LATENCY(L0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_write(w0),
    .req_addr(a0), .req_wdata(wd0), .resp_valid(rv0), .resp_rdata(rd0)
  );

  block_memory #(.LATENCY(L1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_write(w1),
    .req_addr(a1), .req_wdata(wd1), .resp_valid(rv1), .resp_rdata(rd1)
  );

  int           n_assert = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic [127:0] d_q0[$];
  logic [127:0] d_q1[$];
  int           t_q0[$];
  int           t_q1[$];
  int           acc_q0[$];
  int           acc_q1[$];
  logic [127:0] last_rd0;

  localparam logic [127:0] WA = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
  localparam logic [127:0] W1 = {32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
  localparam logic [127:0] W2 = {32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};

  function automatic logic [127:0] blk(input int n);
    return {32'(4*n+3), 32'(4*n+2), 32'(4*n+1), 32'(4*n)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for the LATENCY=4 instance.
  always @(negedge clk) begin
    if (rst) begin
      t_q0.delete();
    end else begin
      if (rv0) begin
        if (d_q0.size() == 0 || t_q0.size() == 0) begin
          chk("unexpected_resp0", 128'(rv0), 128'(0));
        end else begin
          chk("rdata0", rd0, d_q0.pop_front());
          chk("resp_cycle0", 128'(cyc), 128'(t_q0.pop_front()));
        end
      end
      if (v0 && rdy0) begin
        t_q0.push_back(cyc + 1 + L0);
        acc_q0.push_back(cyc + 1);
      end
    end
  end

  // Scoreboard for the LATENCY=1 instance.
  always @(negedge clk) begin
    if (rst) begin
      t_q1.delete();
    end else begin
      if (rv1) begin
        if (d_q1.size() == 0 || t_q1.size() == 0) begin
          chk("unexpected_resp1", 128'(rv1), 128'(0));
        end else begin
          chk("rdata1", rd1, d_q1.pop_front());
          chk("resp_cycle1", 128'(cyc), 128'(t_q1.pop_front()));
        end
      end
      if (v1 && rdy1) begin
        t_q1.push_back(cyc + 1 + L1);
        acc_q1.push_back(cyc + 1);
      end
    end
  end

  task automatic wait_ready0();
    int n = 0;
    while (!rdy0 && n < 20) begin @(posedge clk); #1; n++; end
    chk("ready_timeout0", 128'(rdy0), 128'(1));
  endtask

  task automatic wait_ready1();
    int n = 0;
    while (!rdy1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("ready_timeout1", 128'(rdy1), 128'(1));
  endtask

  task automatic drain0();
    int n = 0;
    while (d_q0.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
    chk("drain0", 128'(d_q0.size()), 128'(0));
  endtask

  task automatic drain1();
    int n = 0;
    while (d_q1.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
    chk("drain1", 128'(d_q1.size()), 128'(0));
  endtask

  // One request on dut0; inputs are scrambled after acceptance.
  task automatic issue0(input logic w, input logic [9:0] a, input logic [127:0] d,
                        input logic [127:0] e);
    wait_ready0();
    d_q0.push_back(e);
    w0 = w; a0 = a; wd0 = d; v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0; wd0 = ~d; a0 = a ^ 10'h2A0;
  endtask

  task automatic rd0_req(input logic [9:0] a, input logic [127:0] e);
    issue0(1'b0, a, '0, e);
    last_rd0 = e;
  endtask

  task automatic wr0_req(input logic [9:0] a, input logic [127:0] d);
    issue0(1'b1, a, d, last_rd0);
  endtask

  initial begin
    int base;
    int n;
    int cyc_deassert;
    rst = 1'b1;
    v0 = 1'b0; w0 = 1'b0; a0 = '0; wd0 = '0;
    v1 = 1'b0; w1 = 1'b0; a1 = '0; wd1 = '0;
    last_rd0 = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_ready", 128'(rdy0), 128'(1));
    chk("reset_valid", 128'(rv0), 128'(0));
    chk("reset_rdata", rd0, '0);
    rst = 1'b0;

    // Read fill with busy window check.
    wait_ready0();
    d_q0.push_back(blk(4));
    last_rd0 = blk(4);
    w0 = 1'b0; a0 = 10'h040; v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0; a0 = 10'h3F0;
    for (int i = 0; i <= L0; i++) begin
      chk("busy_ready", 128'(rdy0), 128'(0));
      @(posedge clk); #1;
    end
    chk("ready_back", 128'(rdy0), 128'(1));
    drain0();

    // Write-back then read of the same block.
    wr0_req(10'h0C0, WA);
    drain0();
    chk("rdata_hold_after_write", rd0, blk(4));
    rd0_req(10'h0C8, WA);
    // Top block and ignored offset.
    rd0_req(10'h3FC, blk(63));
    rd0_req(10'h04C, blk(4));
    drain0();
    chk("rdata_hold", rd0, blk(4));

    // Busy rejection: request held high across a read.
    wait_ready0();
    base = acc_q0.size();
    d_q0.push_back(blk(4));
    last_rd0 = blk(4);
    w0 = 1'b0; a0 = 10'h040; v0 = 1'b1;
    @(posedge clk); #1;
    d_q0.push_back(last_rd0);
    w0 = 1'b1; a0 = 10'h200; wd0 = W1;
    n = 0;
    while (!rdy0 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    wd0 = W2; a0 = 10'h100; v0 = 1'b0;
    chk("busy_accept_count", 128'(acc_q0.size() - base), 128'(2));
    if (acc_q0.size() >= 2) begin
      chk("accept_spacing0", 128'(acc_q0[$] - acc_q0[$-1]), 128'(L0 + 2));
    end
    drain0();
    rd0_req(10'h200, W1);
    drain0();

    // Reset in WAIT aborts a write; request already valid at deassert.
    wait_ready0();
    w0 = 1'b1; a0 = 10'h100; wd0 = '1; v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_ready", 128'(rdy0), 128'(1));
    chk("abort_valid", 128'(rv0), 128'(0));
    chk("abort_rdata", rd0, '0);
    @(posedge clk); #1;
    d_q0.push_back(blk(16));
    last_rd0 = blk(16);
    w0 = 1'b0; a0 = 10'h100; v0 = 1'b1;
    rst = 1'b0;
    cyc_deassert = cyc;
    @(posedge clk); #1;
    v0 = 1'b0;
    chk("accept_after_reset", 128'(acc_q0[$]), 128'(cyc_deassert + 1));
    drain0();

    // LATENCY=1 build: single read then back-to-back stream.
    wait_ready1();
    d_q1.push_back(blk(0));
    w1 = 1'b0; a1 = 10'h000; v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    for (int i = 0; i <= L1; i++) begin
      chk("busy_ready1", 128'(rdy1), 128'(0));
      @(posedge clk); #1;
    end
    chk("ready_back1", 128'(rdy1), 128'(1));
    drain1();
    wait_ready1();
    base = acc_q1.size();
    for (int i = 0; i < 3; i++) d_q1.push_back(blk(0));
    v1 = 1'b1;
    n = 0;
    while (acc_q1.size() < base + 3 && n < 30) begin @(posedge clk); #1; n++; end
    v1 = 1'b0;
    chk("stream_accept_count", 128'(acc_q1.size() - base), 128'(3));
    if (acc_q1.size() >= base + 3) begin
      chk("accept_spacing1a", 128'(acc_q1[base+1] - acc_q1[base]), 128'(3));
      chk("accept_spacing1b", 128'(acc_q1[base+2] - acc_q1[base+1]), 128'(3));
    end
    drain1();

    chk("sb_empty0", 128'(d_q0.size()), 128'(0));
    chk("sb_empty1", 128'(d_q1.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
